// File: rtl/midi_pkg.sv
// Shared MIDI constants, state encodings and the message-length helper used by
// the serial front end (midi_uart_rx and midi_uart_bitrx).
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CH_AT    = 4'hD;
   localparam logic [3:0] PB       = 4'hE;

   localparam logic [7:0] SYS_MIN    = 8'hF0;
   localparam logic [7:0] SYS_RT_MIN = 8'hF8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   typedef enum logic [1:0] {
      OUT_IDLE,
      OUT_STAT,
      OUT_DATA
   } out_state_t;

   // Number of data bytes that follow a channel-voice status byte.
   function automatic logic [1:0] msg_data_len(input logic [7:0] status);
      return (status[7:4] == PROG || status[7:4] == CH_AT) ? 2'd1 : 2'd2;
   endfunction

endpackage

// File: rtl/midi_uart_bitrx.sv
// MIDI bit-level receiver: 2-flop input synchronizer, oversampling tick divider
// and start/data/stop deserializer with break handling after a framing error.
module midi_uart_bitrx
   import midi_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 31250,
   parameter int OVS    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err,
   output logic       rx_active
);

   localparam int DIV = CLK_HZ / (BAUD * OVS);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TW  = $clog2(OVS) + 1;
   localparam logic [TW-1:0] HALF_M1 = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(OVS - 1);

   logic          tick;
   logic          rx_s1, rx_s2;
   rx_state_t     state;
   logic [TW-1:0] tcnt;
   logic [2:0]    bcnt;
   logic [7:0]    shreg;

   generate
      if (DIV <= 1) begin : g_nodiv
         assign tick = 1'b1;
      end else begin : g_div
         logic [DW-1:0] div_cnt;
         always_ff @(posedge clk) begin
            if (reset) div_cnt <= '0;
            else       div_cnt <= (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
         end
         assign tick = (div_cnt == DW'(DIV - 1));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         state     <= RX_IDLE;
         tcnt      <= '0;
         bcnt      <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         rx_s1     <= rx;
         rx_s2     <= rx_s1;
         frame_err <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (!rx_s2) begin
                  tcnt  <= '0;
                  state <= RX_START;
               end
            end
            // Mid-start re-sample rejects glitches shorter than half a bit.
            RX_START: begin
               if (tick) begin
                  if (tcnt == HALF_M1) begin
                     tcnt  <= '0;
                     bcnt  <= '0;
                     state <= rx_s2 ? RX_IDLE : RX_DATA;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  if (tcnt == FULL_M1) begin
                     tcnt  <= '0;
                     shreg <= {rx_s2, shreg[7:1]};
                     bcnt  <= bcnt + 1'b1;
                     if (bcnt == 3'd7) state <= RX_STOP;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            RX_STOP: begin
               if (tick) begin
                  if (tcnt == FULL_M1) begin
                     tcnt <= '0;
                     if (rx_s2) begin
                        state <= RX_IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= RX_BREAK;
                     end
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
            end
            RX_BREAK: begin
               if (rx_s2) state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

   // Valid during the stop-sample cycle so the top can register it at that edge.
   assign byte_valid = (state == RX_STOP) && tick && (tcnt == FULL_M1) && rx_s2;
   assign byte_data  = shreg;
   assign rx_active  = (state != RX_IDLE);

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI serial front end: byte classifier and output sequencer on top of the bit
// receiver. Define MIDI_RUNNING_STATUS_EN for SysEx skip and running-status re-expansion.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 31250,
   parameter int OVS    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       midi_send,
   output logic [7:0] midi_data,
   output logic       frame_err,
   output logic       rx_active
);

   logic       byte_valid;
   logic [7:0] byte_data;
   out_state_t out_state;

   midi_uart_bitrx #(
      .CLK_HZ(CLK_HZ),
      .BAUD  (BAUD),
      .OVS   (OVS)
   ) u_bitrx (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .frame_err (frame_err),
      .rx_active (rx_active)
   );

`ifdef MIDI_RUNNING_STATUS_EN

   logic       rs_valid;
   logic       rs_fresh;
   logic       sx_skip;
   logic [7:0] rs_status;
   logic [1:0] need;
   logic [1:0] cnt;
   logic [7:0] pend;

   always_ff @(posedge clk) begin
      if (reset) begin
         midi_send <= 1'b0;
         midi_data <= 8'h00;
         out_state <= OUT_IDLE;
         rs_valid  <= 1'b0;
         rs_fresh  <= 1'b0;
         sx_skip   <= 1'b0;
         rs_status <= 8'h00;
         need      <= 2'd2;
         cnt       <= 2'd0;
         pend      <= 8'h00;
      end else begin
         midi_send <= 1'b0;
         case (out_state)
            OUT_STAT: begin
               midi_send <= 1'b1;
               midi_data <= pend;
               out_state <= OUT_DATA;
            end
            OUT_DATA: out_state <= OUT_IDLE;
            default:  out_state <= OUT_IDLE;
         endcase

         if (byte_valid) begin
            if (byte_data >= SYS_RT_MIN) begin
               // real-time bytes vanish without touching message state
            end else if (byte_data >= SYS_MIN) begin
               rs_valid <= 1'b0;
               sx_skip  <= 1'b1;
            end else if (byte_data[7]) begin
               midi_send <= 1'b1;
               midi_data <= byte_data;
               out_state <= OUT_DATA;
               rs_status <= byte_data;
               rs_valid  <= 1'b1;
               rs_fresh  <= 1'b1;
               sx_skip   <= 1'b0;
               need      <= msg_data_len(byte_data);
               cnt       <= 2'd0;
            end else if (rs_valid && !sx_skip) begin
               rs_fresh <= 1'b0;
               cnt      <= (cnt + 2'd1 == need) ? 2'd0 : cnt + 2'd1;
               // First data byte of a message whose status went out earlier:
               // replay the status so the translator sees a complete message.
               if (cnt == 2'd0 && !rs_fresh) begin
                  midi_send <= 1'b1;
                  midi_data <= rs_status;
                  pend      <= byte_data;
                  out_state <= OUT_STAT;
               end else begin
                  midi_send <= 1'b1;
                  midi_data <= byte_data;
                  out_state <= OUT_DATA;
               end
            end
         end
      end
   end

`else

   always_ff @(posedge clk) begin
      if (reset) begin
         midi_send <= 1'b0;
         midi_data <= 8'h00;
         out_state <= OUT_IDLE;
      end else begin
         midi_send <= 1'b0;
         if (out_state == OUT_DATA) out_state <= OUT_IDLE;
         if (byte_valid && byte_data < SYS_RT_MIN) begin
            midi_send <= 1'b1;
            midi_data <= byte_data;
            out_state <= OUT_DATA;
         end
      end
   end

`endif

endmodule

// File: tb/tb_midi_uart_rx.sv
// Randomized and directed bench for midi_uart_rx at 16 clk/bit, with a byte-level
// message model predicting every strobe's value and cycle.
`timescale 1ns/1ps
module tb_midi_uart_rx;

   localparam int CLK_HZ   = 500000;
   localparam int BAUD     = 31250;
   localparam int OVS      = 16;
   localparam int BIT_CLKS = 16;
   // start edge -> 2 sync flops + edge detect + half bit + 8 data + stop bit
   localparam int LAT      = 3 + OVS / 2 + 9 * OVS;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       midi_send;
   logic [7:0] midi_data;
   logic       frame_err;
   logic       rx_active;

   midi_uart_rx #(
      .CLK_HZ(CLK_HZ),
      .BAUD  (BAUD),
      .OVS   (OVS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx       (rx),
      .midi_send(midi_send),
      .midi_data(midi_data),
      .frame_err(frame_err),
      .rx_active(rx_active)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] b;
      int         at;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] got[$];
   int         errors = 0;
   int         checks = 0;
   int         ferr_cnt = 0;
   int         ferr_at = -1;

   // message model state
   bit         m_rs_valid;
   bit         m_skip;
   bit         m_fresh;
   logic [7:0] m_status;
   int         m_need;
   int         m_cnt;

   function automatic void push_exp(input logic [7:0] b, input int t);
      exp_t e;
      e.b  = b;
      e.at = t;
      expq.push_back(e);
   endfunction

   function automatic void model_reset();
      m_rs_valid = 0;
      m_skip     = 0;
      m_fresh    = 0;
      m_status   = 8'h00;
      m_need     = 2;
      m_cnt      = 0;
   endfunction

   // t is the cycle the forwarded byte must strobe in
   function automatic void model_byte(input logic [7:0] b, input int t);
`ifdef MIDI_RUNNING_STATUS_EN
      if (b >= 8'hF8) return;
      if (b >= 8'hF0) begin
         m_rs_valid = 0;
         m_skip     = 1;
         return;
      end
      if (b >= 8'h80) begin
         push_exp(b, t);
         m_status   = b;
         m_rs_valid = 1;
         m_skip     = 0;
         m_fresh    = 1;
         m_need     = (b[7:4] == 4'hC || b[7:4] == 4'hD) ? 1 : 2;
         m_cnt      = 0;
         return;
      end
      if (!m_rs_valid || m_skip) return;
      if (m_cnt == 0 && !m_fresh) begin
         push_exp(m_status, t);
         push_exp(b, t + 1);
      end else begin
         push_exp(b, t);
      end
      m_fresh = 0;
      m_cnt   = (m_cnt + 1) % m_need;
`else
      if (b < 8'hF8) push_exp(b, t);
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic chk_seq(input string name, input logic [7:0] req[$]);
      bit ok;
      ok = (got.size() == req.size());
      if (ok) foreach (req[i]) if (got[i] !== req[i]) ok = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d bytes (first %0h), required %0d bytes (first %0h)",
                  name, got.size(), (got.size() > 0) ? got[0] : 8'h00,
                  req.size(), (req.size() > 0) ? req[0] : 8'h00);
      end
      got.delete();
   endtask

   // Called at a negedge; returns at a negedge with the line at the stop level.
   task automatic send_frame(input logic [7:0] b, input bit good_stop, input int stop_len,
                             output int n);
      n  = cyc;
      rx = 1'b0;
      if (good_stop) model_byte(b, n + LAT);
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = good_stop;
      repeat (stop_len) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      send_frame(b, 1'b1, BIT_CLKS, n);
   endtask

   task automatic settle();
      rx = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   // compare process
   exp_t ce;
   always @(negedge clk) begin
      if (!reset) begin
         if (frame_err) begin
            ferr_cnt++;
            ferr_at = cyc;
         end
         if (midi_send) begin
            got.push_back(midi_data);
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL strobe: got %02h at cycle %0d, required no strobe", midi_data, cyc);
            end else begin
               ce = expq.pop_front();
               if (ce.b !== midi_data || ce.at != cyc) begin
                  errors++;
                  $display("FAIL strobe: got %02h at cycle %0d, required %02h at cycle %0d",
                           midi_data, cyc, ce.b, ce.at);
               end
            end
         end else if (expq.size() > 0 && expq[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL strobe: got none by cycle %0d, required %02h at cycle %0d",
                     cyc, expq[0].b, expq[0].at);
            ce = expq.pop_front();
         end
      end
   end

   initial begin
      logic [7:0] lit[$];
      int n;
      int f0;
      logic [7:0] b;
      int r;

      model_reset();
      reset = 1'b1;
      rx    = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      chk("reset midi_send", 32'(midi_send), 32'd0);
      chk("reset midi_data", 32'(midi_data), 32'h00);
      chk("reset frame_err", 32'(frame_err), 32'd0);
      chk("reset rx_active", 32'(rx_active), 32'd0);
      settle();

      // note-on, first frame with a minimum-length stop bit (back-to-back start)
      send_frame(8'h90, 1'b1, 9, n);
      send(8'h3C);
      send(8'h64);
      settle();
      lit = '{8'h90, 8'h3C, 8'h64};
      chk_seq("note_on", lit);

      send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h00);
      settle();
`ifdef MIDI_RUNNING_STATUS_EN
      lit = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h40, 8'h00};
`else
      lit = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h00};
`endif
      chk_seq("running_status", lit);

      send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
      settle();
      lit = '{8'h90, 8'h3C, 8'h64};
      chk_seq("realtime_drop", lit);

      send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h45);
      settle();
`ifdef MIDI_RUNNING_STATUS_EN
      lit.delete();
`else
      lit = '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h45};
`endif
      chk_seq("sysex_skip", lit);
      send(8'hB1); send(8'h07); send(8'h7F);
      settle();
      lit = '{8'hB1, 8'h07, 8'h7F};
      chk_seq("cc_after_sysex", lit);

      // framing error, then line stuck low
      f0 = ferr_cnt;
      send_frame(8'h55, 1'b0, BIT_CLKS, n);
      repeat (500) @(negedge clk);
      chk("frame_err pulses", 32'(ferr_cnt - f0), 32'd1);
      chk("frame_err cycle", 32'(ferr_at), 32'(n + LAT));
      settle();
      send(8'h80);
      settle();
      lit = '{8'h80};
      chk_seq("after_break", lit);

      // short glitch
      f0 = ferr_cnt;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch frame_err", 32'(ferr_cnt - f0), 32'd0);
      lit.delete();
      chk_seq("glitch", lit);

      // reset in the middle of DATA
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = b[0];
         rx = (8'h90 >> i) & 8'h01;
         repeat (BIT_CLKS) @(negedge clk);
      end
      chk("rx_active mid-frame", 32'(rx_active), 32'd1);
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk("post-reset rx_active", 32'(rx_active), 32'd0);
      chk("post-reset midi_send", 32'(midi_send), 32'd0);
      repeat (20) @(negedge clk);
      send(8'h3C);
      settle();
`ifdef MIDI_RUNNING_STATUS_EN
      lit.delete();
`else
      lit = '{8'h3C};
`endif
      chk_seq("reset_mid_frame", lit);

      // randomized traffic with varied stop lengths and idle gaps
      for (int k = 0; k < 40; k++) begin
         r = int'($urandom_range(0, 99));
         if (r < 45)      b = 8'($urandom_range(0, 127));
         else if (r < 75) b = 8'(8'h80 + $urandom_range(0, 111));
         else if (r < 88) b = 8'(8'hF8 + $urandom_range(0, 7));
         else             b = 8'(8'hF0 + $urandom_range(0, 7));
         send_frame(b, 1'b1, int'($urandom_range(9, 16)), n);
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      rx = 1'b1;
      repeat (200) @(negedge clk);
      chk("pending strobes", 32'(expq.size()), 32'd0);
      chk("random frame_err", 32'(ferr_cnt - f0), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/midi_uart_rx.md
# midi_uart_rx

Serial MIDI front end. Deserializes the 31250-baud MIDI line into bytes, filters the byte stream, and presents one complete channel-voice message at a time to the MIDI message translator through a `midi_send`/`midi_data` byte strobe. The translator counts every strobed byte as part of a message, so this block drops real-time and SysEx traffic and re-expands running status.

## Interface
Parameters:
- `CLK_HZ`, 50000000: system clock frequency in Hz.
- `BAUD`, 31250: line rate.
- `OVS`, 16: oversampling ticks per bit.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  raw asynchronous MIDI line; idle high.
- `midi_send`  out  1  one-cycle strobe; `midi_data` is valid while it is high.
- `midi_data`  out  8  forwarded byte.
- `frame_err`  out  1  one-cycle pulse when a byte's stop bit samples low.
- `rx_active`  out  1  high while the deserializer is not idle.

## Operation
- **Input sync:** 2-flop synchronizer on `rx`. The synchronizer flops reset to 1.
- **Tick divider:** `DIV = CLK_HZ/(BAUD*OVS)`, integer, truncated; must be ≥1. The counter free-runs, wraps at `DIV-1`, and emits a one-cycle `tick`.
- **Deserializer FSM:**
  - IDLE: a synced low starts a frame; clear the tick count and go to START.
  - START: after `OVS/2` ticks, re-sample. Low → DATA. High → IDLE (glitch rejected, no output).
  - DATA: sample every `OVS` ticks, 8 bits, LSB first, shifting into the byte register.
  - STOP: sample after `OVS` ticks. High → byte valid, go to IDLE. Low → pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for synced high, then IDLE.
- **Byte classifier** (one valid byte at a time):
  - F8–FF (real-time): dropped. Running-status state is untouched.
  - F0–F7 (system common/SysEx): dropped; running status is invalidated; `sx_skip` is set.
  - 80–EF (channel status): forwarded. Latched as running status; clears `sx_skip`; sets `need` = 2 (1 for Cx/Dx) and `cnt` = 0.
  - 00–7F (data) with `sx_skip` set, or with no valid running status: dropped.
  - 00–7F otherwise: if `cnt == 0` and the status byte for this message has already been sent, re-emit the latched status first; then forward the data byte. `cnt` increments and wraps to 0 when it reaches `need`.
- **Output sequencer:** states OUT_IDLE, OUT_STAT, OUT_DATA. A re-emitted status strobes one cycle, followed by the data byte on the next cycle. Direct forwards use OUT_DATA only.
- `midi_send` is never high on two consecutive cycles except for a status/data injection pair.

## Timing
- **Reset values:** `midi_send`=0, `midi_data`=0x00, `frame_err`=0, `rx_active`=0. FSMs return to IDLE/OUT_IDLE; running status is invalid; `sx_skip`=0.
- **Reset mid-frame:** the partial byte is discarded. No strobe occurs until a full new frame arrives.
- **Latency:** a forwarded byte strobes 1 clk after the cycle the stop bit is sampled. An injected status strobes at +1 and its data byte at +2.
- A byte's frame is ≥ 10·OVS·DIV clks, so the output sequencer is always idle before the next valid byte. No buffering is needed.
- **Back-to-back frames:** a start edge in the cycle after the stop sample must be accepted.
- **`rx` held low indefinitely:** exactly one `frame_err`, then silence until the line returns high.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined: classifier and injection logic as above.
- Not defined: every valid byte except F8–FF is forwarded raw, 1 clk after the stop sample. There is no status tracking, no injection, and no SysEx skip. The sequencer reduces to OUT_IDLE/OUT_DATA.

## Structure
- Package `midi_pkg`:
  - status-nibble constants: NOTE_OFF 8, NOTE_ON 9, POLY_AT A, CC B, PROG C, CH_AT D, PB E
  - `SYS_RT_MIN` = F8
  - function `msg_data_len(status) → 1|2`
- Sub-module `midi_uart_bitrx`: synchronizer, tick divider, and deserializer FSM. Outputs `byte_valid`, `byte_data`, `frame_err`, `rx_active`.
- The classifier and output sequencer live in the top.

## Test plan
Bench uses `CLK_HZ=500000` (DIV=1, 16 clk/bit).
- Frames 0x90, 0x3C, 0x64 → three strobes 0x90/0x3C/0x64, each 1 clk after its stop sample.
- Running status: 0x90, 0x3C, 0x64, 0x40, 0x00 → 0x90, 0x3C, 0x64, then 0x90 and 0x40 on consecutive clks, then 0x00.
- 0xF8 inserted between 0x3C and 0x64 of a note-on → 0xF8 is never strobed; the note message is intact.
- 0xF0, 0x7E, 0x01, 0xF7, 0x45 → no strobes. Then 0xB1, 0x07, 0x7F → three strobes.
- Stop bit forced low on 0x55 → one `frame_err` pulse, no `midi_send`. Line held low 500 clks → no further pulses. Line high, then 0x80 → strobe 0x80.
- 4-clk low glitch on idle line → no strobe, no `frame_err`. Reset asserted mid-DATA of 0x90 → no strobe, and the next 0x3C is dropped (no running status).
